decoder_arbiter: RTL and testbench



---
 rtl/la_pkg.sv | 45 ++++
 rtl/la_rr_pick.sv | 27 ++
 rtl/decoder_arbiter.sv | 139 +++++++++++++
 tb/tb_decoder_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/la_pkg.sv
// Shared definitions for the decoder arbiter: source indices, protocol ids,
// FSM encodings and the FIFO word layout.
package la_pkg;

    localparam int unsigned NUM_SRC    = 3;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned IDX_W      = 2;
    localparam int unsigned PROTO_W    = 2;
    localparam int unsigned DROP_W     = 8;
    localparam int unsigned FIFO_W     = PROTO_W + BYTE_W;

    localparam logic [IDX_W-1:0] SRC_UART = 2'd0;
    localparam logic [IDX_W-1:0] SRC_SPI  = 2'd1;
    localparam logic [IDX_W-1:0] SRC_I2C  = 2'd2;

    localparam logic [PROTO_W-1:0] PROTO_ID_SPI  = 2'b00;
    localparam logic [PROTO_W-1:0] PROTO_ID_I2C  = 2'b01;
    localparam logic [PROTO_W-1:0] PROTO_ID_UART = 2'b10;

    // Pointer value that makes the round-robin search start at uart.
    localparam logic [IDX_W-1:0] PTR_RESET = SRC_I2C;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [PROTO_W-1:0] proto_id;
        logic [BYTE_W-1:0]  data;
    } fifo_word_t;

    function automatic logic [PROTO_W-1:0] proto_of(input logic [IDX_W-1:0] src);
        logic [PROTO_W-1:0] id;
        case (src)
            SRC_UART: id = PROTO_ID_UART;
            SRC_SPI:  id = PROTO_ID_SPI;
            SRC_I2C:  id = PROTO_ID_I2C;
            default:  id = PROTO_ID_SPI;
        endcase
        return id;
    endfunction

endpackage

// File: rtl/la_rr_pick.sv
// Combinational picker: first pending source after ptr, searching
// ptr+1, ptr+2, ptr+3 modulo NUM_SRC.
module la_rr_pick
    import la_pkg::*;
(
    input  logic [NUM_SRC-1:0] pend,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any
);

    logic [IDX_W-1:0] idx;

    always_comb begin : pick_comb
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        for (int k = 1; k <= int'(NUM_SRC); k++) begin
            idx = IDX_W'((32'(ptr) + 32'(k)) % 32'(NUM_SRC));
            if (!any && pend[idx]) begin
                winner = idx;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/decoder_arbiter.sv
// Captures bytes from uart/spi/i2c into per-source holding slots and
// arbitrates them into a capture FIFO. Define DECODER_ARBITER_RR_EN for
// round-robin arbitration; otherwise fixed priority uart > spi > i2c.
module decoder_arbiter
    import la_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       arm,
    input  logic                       stop,
    input  logic [NUM_SRC-1:0]         req_valid,
    input  logic [NUM_SRC*BYTE_W-1:0]  req_data,
    input  logic [NUM_SRC-1:0]         en_mask,
    input  logic                       fifo_full,
    output logic                       fifo_wr_en,
    output logic [FIFO_W-1:0]          fifo_wr_data,
    output logic [NUM_SRC-1:0]         pend,
    output logic [DROP_W-1:0]          drop_cnt,
    output logic [1:0]                 state
);

    state_e               state_q, state_d;
    logic [NUM_SRC-1:0]   pend_q, pend_d;
    logic [BYTE_W-1:0]    slot_q [NUM_SRC];
    logic [DROP_W-1:0]    drop_cnt_q, drop_cnt_d;
    logic                 wr_en_q;
    fifo_word_t           wr_word_q, wr_word_d;
    logic [IDX_W-1:0]     ptr_q;

    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;
    logic                 grant_any;
    logic [NUM_SRC-1:0]   grant_vec;
    logic [NUM_SRC-1:0]   qual_vec;
    logic [NUM_SRC-1:0]   drop_vec;
    logic [NUM_SRC-1:0]   load_vec;
    logic [1:0]           drop_num;
    logic [DROP_W:0]      drop_ext;

    la_rr_pick u_pick (
        .pend   (pend_q),
        .ptr    (ptr_q),
        .winner (pick_idx),
        .any    (pick_any)
    );

`ifdef DECODER_ARBITER_RR_EN
    // Pointer follows the last winner so it gets lowest priority next time.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= PTR_RESET;
        end else if (grant_any) begin
            ptr_q <= pick_idx;
        end
    end
`else
    assign ptr_q = PTR_RESET;
`endif

    always_comb begin : grant_comb
        grant_any = 1'b0;
        grant_vec = '0;
        if (((state_q == ST_RUN) || (state_q == ST_DRAIN)) && !fifo_full && pick_any) begin
            grant_any = 1'b1;
            grant_vec = NUM_SRC'(3'b001 << pick_idx);
        end
        wr_word_d.proto_id = proto_of(pick_idx);
        wr_word_d.data     = slot_q[pick_idx];
    end

    // A busy slot that is not being emptied this edge drops the new byte.
    always_comb begin : capture_comb
        qual_vec = '0;
        if (state_q == ST_RUN) begin
            qual_vec = req_valid & en_mask;
        end
        drop_vec = qual_vec & pend_q & ~grant_vec;
        load_vec = qual_vec & ~drop_vec;
        pend_d   = (pend_q & ~grant_vec) | load_vec;
    end

    always_comb begin : drop_comb
        drop_num = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            drop_num = drop_num + 2'(drop_vec[i]);
        end
        drop_ext   = (DROP_W+1)'(drop_cnt_q) + (DROP_W+1)'(drop_num);
        drop_cnt_d = drop_ext[DROP_W] ? {DROP_W{1'b1}} : drop_ext[DROP_W-1:0];
    end

    always_ff @(posedge clk) begin : state_reg
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : next_state_comb
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (arm)  state_d = ST_RUN;
            ST_RUN:   if (stop) state_d = ST_DRAIN;
            ST_DRAIN: if ((pend_q == '0) && !grant_any) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin : datapath_reg
        if (rst) begin
            pend_q     <= '0;
            drop_cnt_q <= '0;
            wr_en_q    <= 1'b0;
            wr_word_q  <= '0;
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            pend_q     <= pend_d;
            drop_cnt_q <= drop_cnt_d;
            wr_en_q    <= grant_any;
            if (grant_any) begin
                wr_word_q <= wr_word_d;
            end
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                if (load_vec[i]) begin
                    slot_q[i] <= req_data[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = wr_word_q;
    assign pend         = pend_q;
    assign drop_cnt     = drop_cnt_q;
    assign state        = state_q;

endmodule

// File: tb/tb_decoder_arbiter.sv
// Bench for decoder_arbiter: directed scenarios plus random traffic against
// a cycle-level behavioural model of the capture/arbitration rules.
module tb_decoder_arbiter;

    logic        clk = 1'b0;
    logic        rst, arm, stop, fifo_full;
    logic [2:0]  req_valid, en_mask;
    logic [23:0] req_data;
    logic        fifo_wr_en;
    logic [9:0]  fifo_wr_data;
    logic [2:0]  pend;
    logic [7:0]  drop_cnt;
    logic [1:0]  state;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int m_state, m_ptr, m_drop, m_wr_en, m_wr_data;
    int m_pend [3];
    int m_slot [3];
    int proto_tab [3] = '{2, 0, 1};
    int wr_seen;

    decoder_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .arm          (arm),
        .stop         (stop),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .en_mask      (en_mask),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .pend         (pend),
        .drop_cnt     (drop_cnt),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pend_any();
        return (m_pend[0] + m_pend[1] + m_pend[2]) != 0 ? 1 : 0;
    endfunction

    function automatic int pend_bits();
        return m_pend[0] + 2 * m_pend[1] + 4 * m_pend[2];
    endfunction

    // Advance the model by one rising edge using the current inputs.
    task automatic model_edge();
        int g, drops, src, npend [3];
        if (rst) begin
            m_state = 0; m_ptr = 2; m_drop = 0; m_wr_en = 0; m_wr_data = 0;
            for (int i = 0; i < 3; i++) begin m_pend[i] = 0; m_slot[i] = 0; end
            return;
        end
        g = -1;
        if ((m_state == 1 || m_state == 2) && !fifo_full && pend_any() != 0) begin
`ifdef DECODER_ARBITER_RR_EN
            for (int k = 1; k <= 3; k++) begin
                src = (m_ptr + k) % 3;
                if (g < 0 && m_pend[src] != 0) g = src;
            end
            m_ptr = g;
`else
            if (m_pend[0] != 0) g = 0;
            else if (m_pend[1] != 0) g = 1;
            else g = 2;
`endif
        end
        m_wr_en = (g >= 0) ? 1 : 0;
        if (g >= 0) m_wr_data = proto_tab[g] * 256 + m_slot[g];
        drops = 0;
        for (int i = 0; i < 3; i++) begin
            npend[i] = (i == g) ? 0 : m_pend[i];
            if (m_state == 1 && req_valid[i] && en_mask[i]) begin
                if (m_pend[i] != 0 && i != g) drops++;
                else begin
                    m_slot[i] = int'(req_data[i*8 +: 8]);
                    npend[i] = 1;
                end
            end
        end
        m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
        case (m_state)
            0: if (arm) m_state = 1;
            1: if (stop) m_state = 2;
            2: if (pend_any() == 0 && g < 0) m_state = 0;
            default: m_state = 0;
        endcase
        for (int i = 0; i < 3; i++) m_pend[i] = npend[i];
    endtask

    // One clock: update the model, then compare all outputs against it.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("state", 32'(state), 32'(m_state));
        chk("pend", 32'(pend), 32'(pend_bits()));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        chk("wr_en", 32'(fifo_wr_en), 32'(m_wr_en));
        chk("wr_data", 32'(fifo_wr_data), 32'(m_wr_data));
        if (fifo_wr_en) wr_seen++;
    endtask

    task automatic idle_inputs();
        arm = 0; stop = 0; req_valid = 0; req_data = 0; fifo_full = 0;
    endtask

    initial begin
        rst = 1; en_mask = 3'b111; idle_inputs();
        m_state = 0; m_ptr = 2; m_drop = 0; m_wr_en = 0; m_wr_data = 0;
        for (int i = 0; i < 3; i++) begin m_pend[i] = 0; m_slot[i] = 0; end
        wr_seen = 0;

        // Reset values
        cycle(); cycle();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_wr_data", 32'(fifo_wr_data), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);

        // Single spi byte: pend at N+1, write at N+2
        rst = 0; arm = 1; cycle(); arm = 0;
        chk("arm_run", 32'(state), 32'd1);
        req_valid = 3'b010; req_data = 24'h003C00; cycle();
        req_valid = 0;
        chk("spi_pend", 32'(pend), 32'b010);
        chk("spi_wr_en_n1", 32'(fifo_wr_en), 32'd0);
        cycle();
        chk("spi_wr_en", 32'(fifo_wr_en), 32'd1);
        chk("spi_wr_data", 32'(fifo_wr_data), 32'h03C);
        chk("spi_state", 32'(state), 32'd1);

        // Three sources in one cycle
        req_valid = 3'b111; req_data = 24'h5A11A5; cycle();
        req_valid = 0;
        cycle(); chk("tri_0", 32'(fifo_wr_data), 32'h2A5);
        cycle(); chk("tri_1", 32'(fifo_wr_data), 32'h011);
        cycle(); chk("tri_2", 32'(fifo_wr_data), 32'h15A);
        cycle(); chk("tri_idle", 32'(fifo_wr_en), 32'd0);

        // Drop while full, then release
        fifo_full = 1; req_valid = 3'b001; req_data = 24'h000001; cycle();
        req_data = 24'h000002; cycle();
        req_valid = 0;
        chk("full_drop", 32'(drop_cnt), 32'd1);
        fifo_full = 0; cycle();
        chk("full_rel", 32'(fifo_wr_data), 32'h201);
        chk("full_rel_en", 32'(fifo_wr_en), 32'd1);
        cycle(); chk("full_single", 32'(fifo_wr_en), 32'd0);

        // Stop with two pending, traffic during DRAIN is ignored
        fifo_full = 1; req_valid = 3'b011; req_data = 24'h00BBAA; cycle();
        req_valid = 0; stop = 1; cycle(); stop = 0;
        chk("stop_drain", 32'(state), 32'd2);
        fifo_full = 0; req_valid = 3'b111; req_data = 24'h777777; wr_seen = 0;
        for (int i = 0; i < 4; i++) cycle();
        req_valid = 0;
        chk("drain_writes", 32'(wr_seen), 32'd2);
        chk("drain_idle", 32'(state), 32'd0);
        chk("drain_nodrop", 32'(drop_cnt), 32'd1);

        // Saturating drop counter
        arm = 1; cycle(); arm = 0;
        fifo_full = 1; req_valid = 3'b001;
        for (int i = 0; i < 300; i++) begin
            req_data = 24'($urandom_range(0, 255));
            cycle();
        end
        chk("sat_ff", 32'(drop_cnt), 32'hFF);
        cycle();
        chk("sat_hold", 32'(drop_cnt), 32'hFF);
        req_valid = 0; fifo_full = 0; cycle(); cycle();

        // Reset in RUN with all slots pending
        fifo_full = 1; req_valid = 3'b111; req_data = 24'h332211; cycle();
        req_valid = 0;
        chk("pre_rst_pend", 32'(pend), 32'b111);
        rst = 1; fifo_full = 0; cycle();
        chk("rst_run_pend", 32'(pend), 32'd0);
        chk("rst_run_state", 32'(state), 32'd0);
        chk("rst_run_wr", 32'(fifo_wr_en), 32'd0);
        rst = 0; cycle();
        chk("rst_run_nowr", 32'(fifo_wr_en), 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            arm       = ($urandom_range(0, 7) == 0);
            stop      = ($urandom_range(0, 19) == 0);
            fifo_full = ($urandom_range(0, 3) == 0);
            req_valid = 3'($urandom);
            req_data  = 24'($urandom);
            en_mask   = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
